// File: rtl/conv3x3_blur.sv
// 3x3 Gaussian blur (1-2-1 / 2-4-2 / 1-2-1, /16) per RGB channel on a line-buffer window, 3-clock latency.
// Optional macro CONV_BLUR_BYPASS_EN adds a per-beat bypass input forcing centre-pixel passthrough.
module conv3x3_blur #(
    parameter int unsigned WIDTH    = 640,
    parameter int unsigned HEIGHT   = 480,
    parameter int unsigned BUS_SIZE = 25
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
`ifdef CONV_BLUR_BYPASS_EN
    input  logic                          bypass,
`endif
    input  logic [0:2][0:2][BUS_SIZE-1:0] win,
    output logic                          out_valid,
    output logic                          out_sop,
    output logic [23:0]                   out_pixel,
    output logic [$clog2(WIDTH)-1:0]      out_col,
    output logic [$clog2(HEIGHT)-1:0]     out_row,
    output logic                          frame_err
);
    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic {WAIT_SOP, RUN} state_t;

    state_t               state_q;
    logic [COL_W-1:0]     ccol_q, ccol_d, col1_q, col2_q;
    logic [ROW_W-1:0]     crow_q, crow_d, row1_q, row2_q;
    logic                 centre_sop_c, accept_c, err_c, pass_c;
    logic [2:0][2:0][9:0] h_d, h1_q;
    logic [2:0][11:0]     v_d, v2_q;
    logic [23:0]          res_c, pix1_q, pix2_q;
    logic                 vld1_q, vld2_q, sop1_q, sop2_q, pass1_q, pass2_q;
    logic                 unused_tap_sop;

    // Only the centre tap carries a meaningful SOP flag.
    assign unused_tap_sop = ^{win[0][0][BUS_SIZE-1], win[0][1][BUS_SIZE-1], win[0][2][BUS_SIZE-1],
                              win[1][0][BUS_SIZE-1], win[1][2][BUS_SIZE-1],
                              win[2][0][BUS_SIZE-1], win[2][1][BUS_SIZE-1], win[2][2][BUS_SIZE-1]};

    // Beat acceptance, centre position of the current beat and border detection.
    always_comb begin
        centre_sop_c = win[1][1][BUS_SIZE-1];
        accept_c     = in_valid && ((state_q == RUN) || centre_sop_c);
        err_c        = in_valid && (state_q == RUN) && centre_sop_c
                       && !((ccol_q == COL_LAST) && (crow_q == ROW_LAST));
        ccol_d       = ccol_q;
        crow_d       = crow_q;
        if (centre_sop_c) begin
            ccol_d = '0;
            crow_d = '0;
        end else if (ccol_q == COL_LAST) begin
            ccol_d = '0;
            crow_d = (crow_q == ROW_LAST) ? '0 : crow_q + ROW_W'(1);
        end else begin
            ccol_d = ccol_q + COL_W'(1);
        end
        pass_c = (ccol_d == '0) || (ccol_d == COL_LAST) || (crow_d == '0) || (crow_d == ROW_LAST);
`ifdef CONV_BLUR_BYPASS_EN
        pass_c = pass_c || bypass;
`endif
    end

    // Separable kernel: horizontal 1-2-1 per tap line, then vertical 1-2-1, then rounded /16.
    always_comb begin
        h_d   = '0;
        v_d   = '0;
        res_c = '0;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 3; r++) begin
                h_d[k][r] = 10'(win[0][r][8*k +: 8]) + 10'({win[1][r][8*k +: 8], 1'b0})
                          + 10'(win[2][r][8*k +: 8]);
            end
            v_d[k] = 12'(h1_q[k][0]) + 12'({h1_q[k][1], 1'b0}) + 12'(h1_q[k][2]);
            res_c[8*k +: 8] = 8'((v2_q[k] + 12'd8) >> 4);
        end
    end

    // Frame sync FSM, centre position counters and sticky frame error.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= WAIT_SOP;
            ccol_q    <= '0;
            crow_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            if (accept_c) begin
                state_q <= RUN;
                ccol_q  <= ccol_d;
                crow_q  <= crow_d;
            end
            if (err_c) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Three-stage datapath; valid travels alongside the data every clock.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld1_q    <= 1'b0;
            h1_q      <= '0;
            pix1_q    <= '0;
            col1_q    <= '0;
            row1_q    <= '0;
            sop1_q    <= 1'b0;
            pass1_q   <= 1'b0;
            vld2_q    <= 1'b0;
            v2_q      <= '0;
            pix2_q    <= '0;
            col2_q    <= '0;
            row2_q    <= '0;
            sop2_q    <= 1'b0;
            pass2_q   <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_pixel <= '0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            vld1_q    <= accept_c;
            h1_q      <= h_d;
            pix1_q    <= win[1][1][23:0];
            col1_q    <= ccol_d;
            row1_q    <= crow_d;
            sop1_q    <= (ccol_d == '0) && (crow_d == '0);
            pass1_q   <= pass_c;
            vld2_q    <= vld1_q;
            v2_q      <= v_d;
            pix2_q    <= pix1_q;
            col2_q    <= col1_q;
            row2_q    <= row1_q;
            sop2_q    <= sop1_q;
            pass2_q   <= pass1_q;
            out_valid <= vld2_q;
            out_sop   <= vld2_q && sop2_q;
            out_pixel <= pass2_q ? pix2_q : res_c;
            out_col   <= col2_q;
            out_row   <= row2_q;
        end
    end
endmodule

// File: tb/tb_conv3x3_blur.sv
// Scoreboard bench for conv3x3_blur on an 8x6 frame; windows are built directly from a bench image.
module tb_conv3x3_blur;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        logic [23:0] pix;
        int          col;
        int          row;
        bit          sop;
    } exp_t;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic [0:2][0:2][24:0] win;
    logic                 out_valid, out_sop, frame_err;
    logic [23:0]          out_pixel;
    logic [2:0]           out_col, out_row;

    int          n_vec   = 0;
    int          n_err   = 0;
    int          sop_cnt = 0;
    int          sop_mark;
    exp_t        q[$];
    exp_t        mon_e;
    bit          acc  = 1'b0;
    bit          run  = 1'b0;
    int          mcol = 0;
    int          mrow = 0;
    bit [2:0]    sh   = '0;
    logic [23:0] img     [0:H-1][0:W-1];
    logic [23:0] out_img [0:7][0:7];
    logic [23:0] saved_px;

    always #5 clock = ~clock;

    conv3x3_blur #(.WIDTH(W), .HEIGHT(H), .BUS_SIZE(25)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
`ifdef CONV_BLUR_BYPASS_EN
        .bypass    (1'b0),
`endif
        .win       (win),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_pixel (out_pixel),
        .out_col   (out_col),
        .out_row   (out_row),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] blur(input logic [0:2][0:2][24:0] w);
        int          wt [3] = '{1, 2, 1};
        int          s;
        logic [23:0] res;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            s = 0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++)
                    s += wt[c] * wt[r] * int'(w[c][r][8*k +: 8]);
            res[8*k +: 8] = 8'((s + 8) / 16);
        end
        return res;
    endfunction

    // Expected accepted-beat pipeline: out_valid must follow it three clocks later.
    always @(posedge clock) begin
        if (!reset_n) sh <= '0;
        else          sh <= {sh[1:0], acc};
    end

    always @(negedge clock) begin
        chk("out_valid", 32'(out_valid), 32'(sh[2]));
        if (out_valid === 1'b1) begin
            chk("queue_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("out_pixel", 32'(out_pixel), 32'(mon_e.pix));
                chk("out_col", 32'(out_col), 32'(mon_e.col));
                chk("out_row", 32'(out_row), 32'(mon_e.row));
                chk("out_sop", 32'(out_sop), 32'(mon_e.sop));
            end
            out_img[out_row][out_col] = out_pixel;
            if (out_sop === 1'b1) sop_cnt++;
        end
    end

    task automatic drive(input int x, input int y, input bit sop, input bit v);
        exp_t e;
        bit   border;
        @(posedge clock);
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                int xx = x - 1 + c;
                int yy = y - 1 + r;
                if (xx < 0) xx = 0;
                if (xx > W - 1) xx = W - 1;
                if (yy < 0) yy = 0;
                if (yy > H - 1) yy = H - 1;
                win[c][r] = {1'b0, img[yy][xx]};
            end
        end
        win[1][1][24] = sop;
        in_valid = v;
        acc = v && (run || sop);
        if (acc) begin
            if (sop) begin
                mcol = 0;
                mrow = 0;
            end else if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
            run    = 1'b1;
            border = (mcol == 0) || (mcol == W - 1) || (mrow == 0) || (mrow == H - 1);
            e.pix  = border ? img[y][x] : blur(win);
            e.col  = mcol;
            e.row  = mrow;
            e.sop  = (mcol == 0) && (mrow == 0);
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input bit gaps);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                drive(x, y, (x == 0) && (y == 0), 1'b1);
                if (gaps) idle(1);
            end
        end
        idle(4);
    endtask

    task automatic set_img(input int kind);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0:       img[y][x] = 24'h646464;
                    1:       img[y][x] = (x == 4 && y == 3) ? 24'hFFFFFF : 24'h000000;
                    2:       img[y][x] = (y == 2 && (x == 0 || x == 7)) ? 24'h0000FF : 24'h000000;
                    default: img[y][x] = {8'(x * 31), 8'(y * 47), 8'((x * y * 13) % 256)};
                endcase
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sop"}, 32'(out_sop), 32'd0);
        chk({tag, "_pixel"}, 32'(out_pixel), 32'd0);
        chk({tag, "_col"}, 32'(out_col), 32'd0);
        chk({tag, "_row"}, 32'(out_row), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        win      = '0;
        set_img(0);
        repeat (3) @(posedge clock);
        #1;
        chk_zero_outputs("reset");
        reset_n = 1'b1;

        // Beats before any centre SOP are ignored.
        drive(2, 1, 1'b0, 1'b1);
        drive(3, 1, 1'b0, 1'b1);
        drive(4, 1, 1'b0, 1'b1);
        idle(4);

        sop_cnt = 0;
        run_frame(1'b0);
        chk("uniform_sop_count", 32'(sop_cnt), 32'd1);
        chk("uniform_px_3_2", 32'(out_img[2][3]), 32'h646464);
        chk("uniform_px_0_0", 32'(out_img[0][0]), 32'h646464);
        chk("uniform_ferr", 32'(frame_err), 32'd0);

        set_img(1);
        run_frame(1'b0);
        chk("impulse_centre", 32'(out_img[3][4]), 32'h404040);
        chk("impulse_up", 32'(out_img[2][4]), 32'h202020);
        chk("impulse_right", 32'(out_img[3][5]), 32'h202020);
        chk("impulse_diag_ul", 32'(out_img[2][3]), 32'h101010);
        chk("impulse_diag_dr", 32'(out_img[4][5]), 32'h101010);
        chk("impulse_far", 32'(out_img[1][4]), 32'h000000);

        set_img(2);
        run_frame(1'b0);
        chk("edge_left_pass", 32'(out_img[2][0]), 32'h0000FF);
        chk("edge_right_pass", 32'(out_img[2][7]), 32'h0000FF);
        chk("edge_left_blur", 32'(out_img[2][1]), 32'h000020);
        chk("edge_right_blur", 32'(out_img[2][6]), 32'h000020);

        set_img(1);
        run_frame(1'b1);
        chk("gapped_centre", 32'(out_img[3][4]), 32'h404040);
        chk("gapped_left", 32'(out_img[3][3]), 32'h202020);
        chk("gapped_diag", 32'(out_img[4][3]), 32'h101010);
        chk("gapped_ferr", 32'(frame_err), 32'd0);

        // Misplaced centre SOP at (3,2) of a ramp frame.
        set_img(3);
        for (int i = 0; i < 19; i++) drive(i % W, i / W, i == 0, 1'b1);
        chk("ferr_before_bad_sop", 32'(frame_err), 32'd0);
        drive(3, 2, 1'b1, 1'b1);
        idle(1);
        chk("ferr_after_bad_sop", 32'(frame_err), 32'd1);
        drive(4, 2, 1'b0, 1'b1);
        drive(5, 2, 1'b0, 1'b1);
        drive(6, 2, 1'b0, 1'b1);
        idle(4);
        chk("ferr_sticky", 32'(frame_err), 32'd1);
        saved_px = img[2][3];
        chk("resync_px_0_0", 32'(out_img[0][0]), 32'(saved_px));

        // One-cycle reset with beats still in flight.
        drive(7, 2, 1'b0, 1'b1);
        drive(0, 3, 1'b0, 1'b1);
        drive(1, 3, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        acc      = 1'b0;
        run      = 1'b0;
        mcol     = 0;
        mrow     = 0;
        @(negedge clock);
        #1;
        q.delete();
        @(posedge clock);
        #1;
        chk_zero_outputs("midreset");
        reset_n = 1'b1;

        sop_mark = sop_cnt;
        for (int i = 0; i < 5; i++) drive(i, 1, 1'b0, 1'b1);
        idle(4);
        chk("no_output_before_sop", 32'(q.size()), 32'd0);
        chk("no_sop_before_sop", 32'(sop_cnt), 32'(sop_mark));

        run_frame(1'b0);
        chk("ramp_sop_count", 32'(sop_cnt), 32'(sop_mark + 1));
        chk("ramp_ferr", 32'(frame_err), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
